button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, default 3: number of independent button channels (pbR, pbL, pbG at top level).
REQ-002 Parameter ACTIVE_LOW, default 1: 1 means raw input 0 = pressed, 0 means raw input 1 = pressed.
REQ-003 Parameter DB_CYCLES, default 1_000_000: debounce qualification length in clocks (10 ms at 100 MHz); legal range >= 1.
REQ-004 Parameter RPT_DELAY, default 50_000_000: clocks from press pulse to first repeat pulse; legal range >= 1.
REQ-005 Parameter RPT_PERIOD, default 10_000_000: clocks between subsequent repeat pulses; legal range >= 1.
REQ-006 Parameter RPT_MASK, default {N_CH{1'b1}}: per-channel auto-repeat enable.
REQ-007 CLK100MHZ  in  1  single clock; all state updates on its rising edge.
REQ-008 gameReset  in  1  synchronous, active-high reset.
REQ-009 pb_raw  in  N_CH  asynchronous raw button inputs.
REQ-010 pb_level  out  N_CH  debounced level, 1 = pressed, independent of ACTIVE_LOW.
REQ-011 pb_press  out  N_CH  one-cycle pulse on debounced press.
REQ-012 pb_release  out  N_CH  one-cycle pulse on debounced release.
REQ-013 pb_repeat  out  N_CH  one-cycle auto-repeat pulse while held.

Function
REQ-014 Each channel SHALL pass pb_raw through a 2-flop synchronizer, then normalise polarity per ACTIVE_LOW, giving sync_n (1 = pressed).
REQ-015 Each channel SHALL hold a debounce counter of width $clog2(DB_CYCLES+1); it clears on any cycle where sync_n == pb_level.
REQ-016 While sync_n != pb_level: if counter == DB_CYCLES-1, pb_level toggles and counter clears; otherwise counter increments.
REQ-017 Latency: a clean raw transition first sampled at edge 0 SHALL change pb_level at edge DB_CYCLES+1 (DB_CYCLES+2 edges inclusive).
REQ-018 A glitch with mismatch lasting fewer than DB_CYCLES consecutive synchronized cycles SHALL produce no level change and no pulse.
REQ-019 pb_press SHALL be high exactly in the cycle pb_level is 1 following a cycle at 0; pb_release likewise for 1->0.
REQ-020 Each channel SHALL hold a repeat counter of width $clog2(max(RPT_DELAY,RPT_PERIOD)+1), cleared to 0 in the press cycle and whenever pb_level == 0.
REQ-021 Repeat FSM per channel, states IDLE, DELAY, PERIOD: IDLE -> DELAY on press; DELAY -> PERIOD when counter reaches RPT_DELAY-1, emitting pb_repeat and clearing counter; in PERIOD, pb_repeat fires and counter clears each time it reaches RPT_PERIOD-1; any state -> IDLE when pb_level == 0.
REQ-022 First pb_repeat SHALL occur RPT_DELAY cycles after pb_press; subsequent pulses every RPT_PERIOD cycles; pb_press and pb_repeat are never high together.
REQ-023 A channel with RPT_MASK bit 0 SHALL stay in IDLE with pb_repeat held 0.
REQ-024 A release in the same cycle a repeat is due SHALL suppress that repeat; pb_release is still emitted.
REQ-025 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-026 All outputs SHALL be registered; no combinational path from pb_raw to any output.

Reset
REQ-027 While gameReset is high: synchronizer flops load the released raw value (1 if ACTIVE_LOW, else 0), pb_level = 0, all counters = 0, FSMs = IDLE, pb_press = pb_release = pb_repeat = 0.
REQ-028 Reset asserted mid-press SHALL emit no pb_release; if the button is still held after reset deasserts, a full debounce interval SHALL elapse, then one pb_press.

Verification (N_CH=3, ACTIVE_LOW=1, DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3)
REQ-029 Drive pb_raw[0] 1->0 at edge 0, hold -> pb_level[0] and pb_press[0] high at edge 5; pb_press[0] low at edge 6.
REQ-030 Pulse pb_raw[1] low for 3 cycles, then high -> pb_level[1], pb_press[1], pb_release[1] stay 0 throughout.
REQ-031 Hold pb_raw[2] low for 30 cycles after press -> pb_repeat[2] at press+10, +13, +16, +19, ...; release -> pb_release[2] 6 cycles after raw release, no further repeats.
REQ-032 Build with RPT_MASK=3'b011, hold channel 2 for 30 cycles -> pb_repeat[2] never asserts.
REQ-033 Press all three channels on the same edge -> pb_press = 3'b111 in one cycle; release together -> pb_release = 3'b111 in one cycle.
REQ-034 Assert gameReset for 2 cycles while channel 0 is held -> outputs 0 during reset, no pb_release; pb_press[0] reasserts 6 edges after gameReset deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions N_CH raw push-button inputs. Each channel has its own independent
// pipeline:
//   2-flop synchronizer -> polarity normalisation -> debounce counter ->
//   edge pulses -> auto-repeat FSM.
//
// Ports
//   CLK100MHZ   in   1     single clock, all state updates on the rising edge
//   gameReset   in   1     synchronous, active-high reset
//   pb_raw      in   N_CH  asynchronous raw button inputs
//   pb_level    out  N_CH  debounced level, 1 = pressed (independent of ACTIVE_LOW)
//   pb_press    out  N_CH  one-cycle pulse when pb_level rises
//   pb_release  out  N_CH  one-cycle pulse when pb_level falls
//   pb_repeat   out  N_CH  one-cycle auto-repeat pulse while the button is held
//
// Parameters
//   ACTIVE_LOW  1: raw 0 means pressed; 0: raw 1 means pressed
//   DB_CYCLES   consecutive disagreeing samples needed to flip pb_level (>= 1)
//   RPT_DELAY   clocks from pb_press to the first pb_repeat (>= 1)
//   RPT_PERIOD  clocks between later pb_repeat pulses (>= 1)
//   RPT_MASK    per-channel auto-repeat enable
//
// Every output is taken straight from a flop; there is no combinational path
// from pb_raw to any output.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int              N_CH       = 3,
  parameter bit              ACTIVE_LOW = 1'b1,
  parameter int              DB_CYCLES  = 1_000_000,
  parameter int              RPT_DELAY  = 50_000_000,
  parameter int              RPT_PERIOD = 10_000_000,
  parameter logic [N_CH-1:0] RPT_MASK   = {N_CH{1'b1}}
) (
  input  logic            CLK100MHZ,
  input  logic            gameReset,
  input  logic [N_CH-1:0] pb_raw,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_press,
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] pb_repeat
);

  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_D_LAST = RPT_W'(RPT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_P_LAST = RPT_W'(RPT_PERIOD - 1);

  // Raw value of a button that is not being pressed.
  localparam logic RAW_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_PERIOD
  } rpt_state_e;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic             sync1_q;
    logic             sync2_q;
    logic             sync_n;
    logic [DB_W-1:0]  db_cnt_q;
    logic [DB_W-1:0]  db_cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_d;
    logic             release_d;
    logic             press_q;
    logic             release_q;
    rpt_state_e       state_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             repeat_q;

    // Synchronized sample normalised so that 1 always means pressed.
    assign sync_n = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Debounce: the counter measures how long the synchronized input has
    // disagreed with the debounced level; any agreement restarts it.
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync_n != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          level_d = ~level_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      // Pulses are computed from the next level so they line up with it.
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
    end

    // NOTE: flops are updated with non-blocking assignments so every register
    // samples the pre-edge value of its neighbours (the synchronizer chain
    // depends on this).
    always_ff @(posedge CLK100MHZ) begin
      if (gameReset) begin
        // Synchronizer loads the released value so leaving reset never looks
        // like a release or a spurious press.
        sync1_q   <= RAW_IDLE;
        sync2_q   <= RAW_IDLE;
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync1_q   <= pb_raw[ch];
        sync2_q   <= sync1_q;
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Auto-repeat FSM. It follows the next debounced level, so a release in
    // the cycle a repeat falls due sends the FSM to IDLE and drops that pulse.
    always_ff @(posedge CLK100MHZ) begin
      if (gameReset || !RPT_MASK[ch] || !level_d) begin
        state_q   <= ST_IDLE;
        rpt_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else if (press_d) begin
        state_q   <= ST_DELAY;
        rpt_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else begin
        repeat_q <= 1'b0;
        case (state_q)
          ST_DELAY: begin
            if (rpt_cnt_q == RPT_D_LAST) begin
              repeat_q  <= 1'b1;
              rpt_cnt_q <= '0;
              state_q   <= ST_PERIOD;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
            end
          end
          ST_PERIOD: begin
            if (rpt_cnt_q == RPT_P_LAST) begin
              repeat_q  <= 1'b1;
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            rpt_cnt_q <= '0;
          end
        endcase
      end
    end

    assign pb_level[ch]   = level_q;
    assign pb_press[ch]   = press_q;
    assign pb_release[ch] = release_q;
    assign pb_repeat[ch]  = repeat_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Two instances share one stimulus: dut_a repeats on every channel, dut_b has
// auto-repeat disabled on channel 2. Directed scenarios check spec-derived
// edge numbers; a randomized run compares both instances every cycle against
// a reference model that decides debounced levels from a window of past raw
// samples and repeat pulses from the distance to the last press.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk;
  logic         game_reset;
  logic [N-1:0] pb_raw;
  logic [N-1:0] a_level, a_press, a_rel, a_rep;
  logic [N-1:0] b_level, b_press, b_rel, b_rep;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_CH(N), .ACTIVE_LOW(1'b1), .DB_CYCLES(DB),
    .RPT_DELAY(RD), .RPT_PERIOD(RP), .RPT_MASK(3'b111)
  ) dut_a (
    .CLK100MHZ (clk),
    .gameReset (game_reset),
    .pb_raw    (pb_raw),
    .pb_level  (a_level),
    .pb_press  (a_press),
    .pb_release(a_rel),
    .pb_repeat (a_rep)
  );

  button_conditioner #(
    .N_CH(N), .ACTIVE_LOW(1'b1), .DB_CYCLES(DB),
    .RPT_DELAY(RD), .RPT_PERIOD(RP), .RPT_MASK(3'b011)
  ) dut_b (
    .CLK100MHZ (clk),
    .gameReset (game_reset),
    .pb_raw    (pb_raw),
    .pb_level  (b_level),
    .pb_press  (b_press),
    .pb_release(b_rel),
    .pb_repeat (b_rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model. hist holds "pressed" as sampled at each edge; the level
  // seen by the debouncer at edge t is the sample from edge t-2. The level
  // flips when the last DB such samples all disagree with it. Repeats fall at
  // press + RD + k*RP while the level stays high.
  // ---------------------------------------------------------------------------
  bit           hist [N][16];
  bit           m_level [N];
  int           m_pt [N];
  int           t_m = 0;
  logic [N-1:0] mask_b = 3'b011;
  logic [N-1:0] exp_level = '0, exp_press = '0, exp_rel = '0;
  logic [N-1:0] exp_rep_a = '0, exp_rep_b = '0;
  bit           m_want, m_match, m_new;

  always @(posedge clk) begin
    for (int ch = 0; ch < N; ch++) begin
      if (game_reset) begin
        hist[ch][t_m % 16]        = 1'b0;
        hist[ch][(t_m + 15) % 16] = 1'b0;
        m_level[ch]   = 1'b0;
        m_pt[ch]      = -1;
        exp_level[ch] = 1'b0;
        exp_press[ch] = 1'b0;
        exp_rel[ch]   = 1'b0;
        exp_rep_a[ch] = 1'b0;
        exp_rep_b[ch] = 1'b0;
      end else begin
        hist[ch][t_m % 16] = ~pb_raw[ch];
        m_want  = ~m_level[ch];
        m_match = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (hist[ch][(t_m + 64 - k) % 16] != m_want) m_match = 1'b0;
        m_new = m_match ? m_want : m_level[ch];
        exp_press[ch] = m_new & ~m_level[ch];
        exp_rel[ch]   = ~m_new & m_level[ch];
        if (exp_press[ch]) m_pt[ch] = t_m;
        exp_rep_a[ch] = m_new && !exp_press[ch] && m_pt[ch] >= 0 &&
                        (t_m - m_pt[ch]) >= RD &&
                        ((t_m - m_pt[ch] - RD) % RP == 0);
        exp_rep_b[ch] = exp_rep_a[ch] & mask_b[ch];
        m_level[ch]   = m_new;
        exp_level[ch] = m_new;
      end
    end
    t_m++;
  end

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    game_reset = 1'b0;
    pb_raw     = '1;
    repeat (10) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if ({a_level, a_press, a_rel, a_rep} !== 12'h000) begin
        errors++;
        $display("FAIL reset.a e=%0d got %h want 000", e, {a_level, a_press, a_rel, a_rep});
      end
      checks++;
      if ({b_level, b_press, b_rel, b_rep} !== 12'h000) begin
        errors++;
        $display("FAIL reset.b e=%0d got %h want 000", e, {b_level, b_press, b_rel, b_rep});
      end
    end
    game_reset = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if ({a_level, a_press, a_rel, a_rep} !== 12'h000) begin
        errors++;
        $display("FAIL idle.a e=%0d got %h want 000", e, {a_level, a_press, a_rel, a_rep});
      end
      checks++;
      if ({b_level, b_press, b_rel, b_rep} !== 12'h000) begin
        errors++;
        $display("FAIL idle.b e=%0d got %h want 000", e, {b_level, b_press, b_rel, b_rep});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_press_latency();
    settle();
    pb_raw[0] = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (a_level[0] !== (e >= 5)) begin
        errors++;
        $display("FAIL press_latency.level e=%0d got %b want %b", e, a_level[0], (e >= 5));
      end
      checks++;
      if (a_press[0] !== (e == 5)) begin
        errors++;
        $display("FAIL press_latency.press e=%0d got %b want %b", e, a_press[0], (e == 5));
      end
    end
    pb_raw[0] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (a_level[0] !== (e < 5)) begin
        errors++;
        $display("FAIL release_latency.level e=%0d got %b want %b", e, a_level[0], (e < 5));
      end
      checks++;
      if (a_rel[0] !== (e == 5)) begin
        errors++;
        $display("FAIL release_latency.release e=%0d got %b want %b", e, a_rel[0], (e == 5));
      end
      checks++;
      if (a_rep !== 3'b000) begin
        errors++;
        $display("FAIL release_latency.repeat e=%0d got %b want 000", e, a_rep);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_glitch();
    settle();
    // Three-cycle glitch: too short to qualify.
    for (int e = 0; e < 15; e++) begin
      pb_raw[1] = (e < 3) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({a_level[1], a_press[1], a_rel[1]} !== 3'b000) begin
        errors++;
        $display("FAIL glitch e=%0d got %b want 000", e, {a_level[1], a_press[1], a_rel[1]});
      end
    end
    settle();
    // Exactly DB_CYCLES low: the shortest pulse that qualifies.
    for (int e = 0; e < 13; e++) begin
      pb_raw[1] = (e < 4) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if ({a_level[1], a_press[1], a_rel[1]} !== {(e >= 5 && e < 9), (e == 5), (e == 9)}) begin
        errors++;
        $display("FAIL min_pulse e=%0d got %b want %b", e, {a_level[1], a_press[1], a_rel[1]},
                 {(e >= 5 && e < 9), (e == 5), (e == 9)});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Press at edge 5, repeats at 15,18,...,36; release lands at 39, where a
  // repeat would also be due and must be dropped.
  task automatic test_repeat();
    bit exp_r;
    settle();
    for (int e = 0; e < 46; e++) begin
      pb_raw[2] = (e < 34) ? 1'b0 : 1'b1;
      tick();
      exp_r = (e >= 15) && (e <= 36) && ((e - 15) % 3 == 0);
      checks++;
      if (a_rep[2] !== exp_r) begin
        errors++;
        $display("FAIL repeat.a e=%0d got %b want %b", e, a_rep[2], exp_r);
      end
      checks++;
      if (b_rep !== 3'b000) begin
        errors++;
        $display("FAIL repeat_masked.b e=%0d got %b want 000", e, b_rep);
      end
      checks++;
      if ({a_press[2], a_rel[2], b_press[2], b_rel[2]} !== {(e == 5), (e == 39), (e == 5), (e == 39)}) begin
        errors++;
        $display("FAIL repeat.edges e=%0d got %b want %b", e, {a_press[2], a_rel[2], b_press[2], b_rel[2]},
                 {(e == 5), (e == 39), (e == 5), (e == 39)});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    logic [N-1:0] want_p, want_r;
    settle();
    for (int e = 0; e < 17; e++) begin
      pb_raw = (e < 8) ? 3'b000 : 3'b111;
      tick();
      want_p = (e == 5) ? 3'b111 : 3'b000;
      want_r = (e == 13) ? 3'b111 : 3'b000;
      checks++;
      if ({a_press, a_rel, a_rep} !== {want_p, want_r, 3'b000}) begin
        errors++;
        $display("FAIL simultaneous.a e=%0d got %b want %b", e, {a_press, a_rel, a_rep}, {want_p, want_r, 3'b000});
      end
      checks++;
      if ({b_press, b_rel} !== {want_p, want_r}) begin
        errors++;
        $display("FAIL simultaneous.b e=%0d got %b want %b", e, {b_press, b_rel}, {want_p, want_r});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Channel 0 held throughout; reset on edges 8 and 9 only.
  task automatic test_reset_mid_press();
    settle();
    for (int e = 0; e < 21; e++) begin
      pb_raw[0]  = 1'b0;
      game_reset = (e == 8 || e == 9);
      tick();
      if (e == 8 || e == 9) begin
        checks++;
        if ({a_level, a_press, a_rel, a_rep, b_level, b_press, b_rel, b_rep} !== 24'h0) begin
          errors++;
          $display("FAIL reset_mid.outputs e=%0d got %h want 000000", e,
                   {a_level, a_press, a_rel, a_rep, b_level, b_press, b_rel, b_rep});
        end
      end
      checks++;
      if ({a_rel[0], b_rel[0]} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid.release e=%0d got %b want 00", e, {a_rel[0], b_rel[0]});
      end
      checks++;
      if ({a_level[0], a_press[0]} !== {((e >= 5 && e < 8) || e >= 15), (e == 5 || e == 15)}) begin
        errors++;
        $display("FAIL reset_mid.press e=%0d got %b want %b", e, {a_level[0], a_press[0]},
                 {((e >= 5 && e < 8) || e >= 15), (e == 5 || e == 15)});
      end
    end
    settle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    int dur [N];
    int rst_left;
    rst_left   = 0;
    game_reset = 1'b0;
    pb_raw     = '1;
    for (int ch = 0; ch < N; ch++) dur[ch] = $urandom_range(1, 40);
    for (int c = 0; c < 2000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (dur[ch] == 0) begin
          pb_raw[ch] = ~pb_raw[ch];
          dur[ch]    = $urandom_range(1, 40);
        end else begin
          dur[ch]--;
        end
      end
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      game_reset = (rst_left > 0);
      tick();
      checks++;
      if ({a_level, a_press, a_rel, a_rep} !== {exp_level, exp_press, exp_rel, exp_rep_a}) begin
        errors++;
        $display("FAIL random.a c=%0d got %b want %b", c, {a_level, a_press, a_rel, a_rep},
                 {exp_level, exp_press, exp_rel, exp_rep_a});
      end
      checks++;
      if ({b_level, b_press, b_rel, b_rep} !== {exp_level, exp_press, exp_rel, exp_rep_b}) begin
        errors++;
        $display("FAIL random.b c=%0d got %b want %b", c, {b_level, b_press, b_rel, b_rep},
                 {exp_level, exp_press, exp_rel, exp_rep_b});
      end
    end
    game_reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    game_reset = 1'b1;
    pb_raw     = '1;
    test_reset();
    test_press_latency();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_reset_mid_press();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
